sp_ram_march_bist: RTL and testbench
====================================

SP_RAM_MARCH_BIST -- requirements
Module: sp_ram_march_bist

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, the RAM word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, the RAM data width; it is a multiple of 8.
REQ-003 The block SHALL have parameter NUM_WORDS, default 256, the locations tested (0..NUM_WORDS-1); NUM_WORDS <= 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter BACKGROUND, default all-zeros, the DATA_WIDTH-bit data background (D); ~D is its bitwise complement.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 start_i  input  1  starts one test run when sampled high in IDLE.
REQ-008 busy_o  output  1  test in progress.
REQ-009 done_o  output  1  one-cycle pulse at end of run.
REQ-010 fail_o  output  1  sticky: at least one read mismatch in the current/last run.
REQ-011 fail_addr_o  output  ADDR_WIDTH  address of first mismatch.
REQ-012 fail_data_o  output  DATA_WIDTH  rdata observed at first mismatch.
REQ-013 en_o, we_o  output  1 each  RAM enable / write enable.
REQ-014 addr_o  output  ADDR_WIDTH  RAM word address.
REQ-015 wdata_o  output  DATA_WIDTH  RAM write data.
REQ-016 be_o  output  DATA_WIDTH/8  RAM byte enables.
REQ-017 rdata_i  input  DATA_WIDTH  RAM read data, valid the cycle after a read (en_o=1, we_o=0) is issued.

Function
REQ-018 The block SHALL run March C- as six elements: M0 up(w D); M1 up(r D, w ~D); M2 up(r ~D, w D); M3 down(r D, w ~D); M4 down(r ~D, w D); M5 up(r D).
REQ-019 States SHALL be IDLE, M0..M5, DRAIN, DONE; IDLE->M0 on start_i, Mk->Mk+1 after the last address of Mk, M5->DRAIN->DONE->IDLE.
REQ-020 "up" SHALL run addresses 0 to NUM_WORDS-1; "down" SHALL run NUM_WORDS-1 to 0; the counter SHALL not wrap within an element.
REQ-021 M0 and M5 SHALL spend 1 cycle per address; M1-M4 SHALL spend 2 cycles per address: read cycle, then write cycle to the same address.
REQ-022 Every operation cycle SHALL have en_o=1; en_o SHALL be 0 in IDLE, DRAIN and DONE.
REQ-023 we_o SHALL be 1 only in write cycles; be_o SHALL be all-ones when we_o=1, all-zeros otherwise.
REQ-024 wdata_o SHALL equal the element's write value in write cycles and all-zeros otherwise.
REQ-025 For a start_i sampled at edge S, the first operation SHALL occur in cycle S+1 and the last read in cycle S+10*NUM_WORDS.
REQ-026 Each read's expected value and address SHALL be registered, and rdata_i SHALL be compared in the following cycle.
REQ-027 The compare SHALL happen in parallel with the next operation, including the write to the same address.
REQ-028 On the first mismatch of a run, fail_o SHALL set and fail_addr_o/fail_data_o SHALL capture; later mismatches SHALL not overwrite them.
REQ-029 The run SHALL continue to completion after a mismatch.
REQ-030 DRAIN SHALL be the compare cycle of the last M5 read (cycle S+10*NUM_WORDS+1).
REQ-031 done_o SHALL be 1 only in DONE, cycle S+10*NUM_WORDS+2, when fail outputs are final.
REQ-032 busy_o SHALL be 1 in cycles S+1 through S+10*NUM_WORDS+1.
REQ-033 start_i SHALL be ignored outside IDLE, including in DONE.
REQ-034 An accepted start_i SHALL clear fail_o, fail_addr_o and fail_data_o at edge S.
REQ-035 With NUM_WORDS=1, each element SHALL perform exactly one address, with the same timing formulas.

Reset
REQ-036 rst_n low SHALL immediately force state IDLE and all outputs to 0, independent of clk.
REQ-037 Reset mid-run SHALL abandon the run with no further RAM access; a new start_i is required.
REQ-038 The first start_i SHALL be accepted at the first rising edge after rst_n deasserts.

Verification
REQ-039 Fault-free RAM, NUM_WORDS=256, D=0, start at S -> 1280 writes and 1280 reads; done_o at S+2562; fail_o=0.
REQ-040 RAM word 0x05 bit 0 stuck-at-1, D=0 -> fail_o=1, fail_addr_o=0x05, fail_data_o=0x00000001 (first hit in M1); done_o still at S+2562.
REQ-041 Address trace check -> M3/M4 addr_o runs 0xFF..0x00; M0/M1/M2/M5 runs 0x00..0xFF; read/write pairs use the same address.
REQ-042 start_i pulsed at S+100 -> ignored; done_o exactly once at S+2562.
REQ-043 rst_n low at S+500 for 3 cycles -> outputs 0 asynchronously; no en_o until next start; a new run passes.
REQ-044 Run 1 fails at 0x05, fault removed, run 2 -> fail_o clears at its start; run 2 ends with fail_o=0.

Source files
------------

// File: rtl/sp_ram_march_bist.sv
// March C- built-in self test for a single-port synchronous RAM with one-cycle read latency.
// Each read is checked one cycle later, overlapped with the next RAM operation.
module sp_ram_march_bist #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_WORDS  = 256,
  parameter logic [DATA_WIDTH-1:0] BACKGROUND = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    fail_o,
  output logic [ADDR_WIDTH-1:0]   fail_addr_o,
  output logic [DATA_WIDTH-1:0]   fail_data_o,
  output logic                    en_o,
  output logic                    we_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   wdata_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  input  logic [DATA_WIDTH-1:0]   rdata_i
);

  localparam int                    BE_W = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    phase_q;  // within M1..M4: 0 = read cycle, 1 = write cycle

  logic                    is_op, up, two_ph, elem_end, we, rd;
  logic [DATA_WIDTH-1:0]   wval, rexp;

  logic                    rd_vld_p0;
  logic [DATA_WIDTH-1:0]   exp_p0;
  logic [ADDR_WIDTH-1:0]   addr_p0;

  logic                    fail_q;
  logic [ADDR_WIDTH-1:0]   fail_addr_q;
  logic [DATA_WIDTH-1:0]   fail_data_q;

  always_comb begin
    state_d  = state_q;
    is_op    = 1'b0;
    up       = 1'b1;
    two_ph   = 1'b0;
    wval     = '0;
    rexp     = '0;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_M0;
      S_M0:    begin is_op = 1'b1; wval = BACKGROUND; end
      S_M1:    begin is_op = 1'b1; two_ph = 1'b1; rexp = BACKGROUND;  wval = ~BACKGROUND; end
      S_M2:    begin is_op = 1'b1; two_ph = 1'b1; rexp = ~BACKGROUND; wval = BACKGROUND;  end
      S_M3:    begin is_op = 1'b1; two_ph = 1'b1; up = 1'b0; rexp = BACKGROUND;  wval = ~BACKGROUND; end
      S_M4:    begin is_op = 1'b1; two_ph = 1'b1; up = 1'b0; rexp = ~BACKGROUND; wval = BACKGROUND;  end
      S_M5:    begin is_op = 1'b1; rexp = BACKGROUND; end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // An element ends on its final address, after the write half when it has one
    elem_end = is_op && (up ? (addr_q == LAST) : (addr_q == '0)) && (!two_ph || phase_q);
    if (elem_end) begin
      case (state_q)
        S_M0:    state_d = S_M1;
        S_M1:    state_d = S_M2;
        S_M2:    state_d = S_M3;
        S_M3:    state_d = S_M4;
        S_M4:    state_d = S_M5;
        S_M5:    state_d = S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end

    we = is_op && (two_ph ? phase_q : (state_q == S_M0));
    rd = is_op && !we;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (elem_end) begin
        phase_q <= 1'b0;
        // M3 and M4 walk downwards, so they start from the top address
        addr_q  <= (state_q == S_M2 || state_q == S_M3) ? LAST : '0;
      end else if (two_ph && !phase_q) begin
        phase_q <= 1'b1;
      end else if (is_op) begin
        phase_q <= 1'b0;
        addr_q  <= up ? addr_q + ADDR_WIDTH'(1) : addr_q - ADDR_WIDTH'(1);
      end else begin
        phase_q <= 1'b0;
        addr_q  <= '0;
      end
    end
  end

  // ---- p0: read issued; hold its expectation until rdata_i returns ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld_p0 <= 1'b0;
    else        rd_vld_p0 <= rd;
  end

  always_ff @(posedge clk) begin
    if (rd) begin
      exp_p0  <= rexp;
      addr_p0 <= addr_q;
    end
  end

  // ---- p1: compare returned data, latch only the first mismatch of a run ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (state_q == S_IDLE && start_i) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (rd_vld_p0 && (rdata_i != exp_p0) && !fail_q) begin
      fail_q      <= 1'b1;
      fail_addr_q <= addr_p0;
      fail_data_q <= rdata_i;
    end
  end

  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_data_o = fail_data_q;
  assign en_o        = is_op;
  assign we_o        = we;
  assign addr_o      = is_op ? addr_q : '0;
  assign wdata_o     = we ? wval : '0;
  assign be_o        = we ? {BE_W{1'b1}} : '0;

endmodule

// File: tb/tb_sp_ram_march_bist.sv
// Directed bench for sp_ram_march_bist: 256-word instance with a behavioural RAM
// (optional stuck-at-1 on word 0x05 bit 0) and a 1-word instance.
module tb_sp_ram_march_bist;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int NW = 256;
  localparam logic [DW-1:0] D = '0;

  localparam int AW1 = 2;
  localparam int DW1 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start_i, busy_o, done_o, fail_o, en_o, we_o;
  logic [AW-1:0] fail_addr_o, addr_o;
  logic [DW-1:0] fail_data_o, wdata_o, rdata_i;
  logic [3:0]    be_o;

  logic           start1, busy1, done1, fail1, en1, we1;
  logic [AW1-1:0] faddr1, addr1;
  logic [DW1-1:0] fdata1, wdata1, rdata1;
  logic [0:0]     be1;

  sp_ram_march_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WORDS(NW), .BACKGROUND(D)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .fail_o(fail_o), .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o),
    .en_o(en_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o),
    .rdata_i(rdata_i)
  );

  sp_ram_march_bist #(.ADDR_WIDTH(AW1), .DATA_WIDTH(DW1), .NUM_WORDS(1), .BACKGROUND(8'hA5)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .fail_o(fail1), .fail_addr_o(faddr1), .fail_data_o(fdata1),
    .en_o(en1), .we_o(we1), .addr_o(addr1), .wdata_o(wdata1), .be_o(be1),
    .rdata_i(rdata1)
  );

  logic [DW-1:0]  mem  [NW];
  logic [DW1-1:0] mem1 [4];
  bit stuck_en = 1'b0;

  always @(posedge clk) begin
    if (en_o && we_o)
      for (int b = 0; b < DW/8; b++)
        if (be_o[b]) mem[addr_o][b*8 +: 8] <= wdata_o[b*8 +: 8];
    if (en_o && !we_o)
      rdata_i <= mem[addr_o] | ((stuck_en && addr_o == 8'h05) ? 32'h1 : 32'h0);
  end

  always @(posedge clk) begin
    if (en1 && we1 && be1[0]) mem1[addr1] <= wdata1;
    if (en1 && !we1) rdata1 <= mem1[addr1];
  end

  int checks = 0;
  int errors = 0;

  int r_wr, r_rd, r_done_cnt, r_done_k, r_first_k, r_last_rd_k, r_trace_err, r_busy_err;
  logic          r_fail_k1, r_fail_end;
  logic [AW-1:0] r_faddr;
  logic [DW-1:0] r_fdata;

  // Independent reference for the operation sequence: op index -> address/we/wdata
  task automatic model(input int o, output logic [AW-1:0] a, output logic w, output logic [DW-1:0] wd);
    int t, b, r, j;
    if (o < NW) begin
      a = AW'(o); w = 1'b1; wd = D;
    end else if (o < 9*NW) begin
      t = o - NW; b = t / (2*NW); r = t % (2*NW); j = r / 2;
      a  = (b < 2) ? AW'(j) : AW'(NW - 1 - j);
      w  = (r % 2 == 1);
      wd = w ? ((b % 2 == 0) ? ~D : D) : '0;
    end else begin
      a = AW'(o - 9*NW); w = 1'b0; wd = '0;
    end
  endtask

  // Caller invokes this between edges; the next rising edge is S.
  task automatic run_march(input bit pulse_mid, input bit start_in_done);
    int ops;
    logic [AW-1:0] ea;
    logic          ewe;
    logic [DW-1:0] ewd;
    r_wr = 0; r_rd = 0; r_done_cnt = 0; r_done_k = -1; r_first_k = -1;
    r_last_rd_k = -1; r_trace_err = 0; r_busy_err = 0;
    r_fail_k1 = 1'bx; r_fail_end = 1'bx; r_faddr = 'x; r_fdata = 'x;
    ops = 0;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    for (int k = 1; k <= 10*NW + 5; k++) begin
      if (k == 1) r_fail_k1 = fail_o;
      if (busy_o !== (k <= 10*NW + 1)) r_busy_err++;
      if (en_o !== (k <= 10*NW)) r_trace_err++;
      if (en_o === 1'b1) begin
        model(ops, ea, ewe, ewd);
        if (addr_o !== ea || we_o !== ewe || wdata_o !== ewd || be_o !== (ewe ? 4'hF : 4'h0))
          r_trace_err++;
        if (r_first_k < 0) r_first_k = k;
        if (we_o) r_wr++;
        else begin r_rd++; r_last_rd_k = k; end
        ops++;
      end else if (we_o !== 1'b0 || be_o !== 4'h0 || wdata_o !== '0 || addr_o !== '0) begin
        r_trace_err++;
      end
      if (done_o === 1'b1) begin
        r_done_cnt++; r_done_k = k;
        r_fail_end = fail_o; r_faddr = fail_addr_o; r_fdata = fail_data_o;
      end
      start_i = (pulse_mid && k == 100) || (start_in_done && k == 10*NW + 2);
      @(negedge clk);
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start_i = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_o, done_o, fail_o, en_o, we_o} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy_o, done_o, fail_o, en_o, we_o});
    end
    checks++;
    if (addr_o !== '0 || wdata_o !== '0 || be_o !== '0) begin
      errors++; $display("FAIL reset_ram: addr=%h wdata=%h be=%h expected all 0", addr_o, wdata_o, be_o);
    end
    checks++;
    if (fail_addr_o !== '0 || fail_data_o !== '0) begin
      errors++; $display("FAIL reset_failinfo: addr=%h data=%h expected 0", fail_addr_o, fail_data_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fault_free;
    stuck_en = 1'b0;
    run_march(1'b0, 1'b0);
    checks++; if (r_first_k !== 1) begin errors++; $display("FAIL first_op: cycle S+%0d expected S+1", r_first_k); end
    checks++; if (r_wr !== 1280) begin errors++; $display("FAIL write_count: got %0d expected 1280", r_wr); end
    checks++; if (r_rd !== 1280) begin errors++; $display("FAIL read_count: got %0d expected 1280", r_rd); end
    checks++; if (r_last_rd_k !== 2560) begin errors++; $display("FAIL last_read: cycle S+%0d expected S+2560", r_last_rd_k); end
    checks++; if (r_done_k !== 2562) begin errors++; $display("FAIL done_cycle: S+%0d expected S+2562", r_done_k); end
    checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL done_count: got %0d expected 1", r_done_cnt); end
    checks++; if (r_fail_end !== 1'b0) begin errors++; $display("FAIL clean_fail: got %b expected 0", r_fail_end); end
    checks++; if (r_trace_err !== 0) begin errors++; $display("FAIL addr_trace: %0d bad cycles expected 0", r_trace_err); end
    checks++; if (r_busy_err !== 0) begin errors++; $display("FAIL busy_window: %0d bad cycles expected 0", r_busy_err); end
  endtask

  task automatic test_stuck_fault;
    stuck_en = 1'b1;
    run_march(1'b0, 1'b0);
    checks++; if (r_fail_end !== 1'b1) begin errors++; $display("FAIL stuck_fail: got %b expected 1", r_fail_end); end
    checks++; if (r_faddr !== 8'h05) begin errors++; $display("FAIL stuck_addr: got %h expected 05", r_faddr); end
    checks++; if (r_fdata !== 32'h00000001) begin errors++; $display("FAIL stuck_data: got %h expected 00000001", r_fdata); end
    checks++; if (r_done_k !== 2562) begin errors++; $display("FAIL stuck_done: S+%0d expected S+2562", r_done_k); end
  endtask

  task automatic test_fault_cleared;
    stuck_en = 1'b0;
    run_march(1'b0, 1'b0);
    checks++; if (r_fail_k1 !== 1'b0) begin errors++; $display("FAIL fail_clear_at_start: got %b expected 0", r_fail_k1); end
    checks++;
    if (r_fail_end !== 1'b0 || r_faddr !== '0 || r_fdata !== '0) begin
      errors++; $display("FAIL rerun_clean: fail=%b addr=%h data=%h expected 0/00/00000000", r_fail_end, r_faddr, r_fdata);
    end
  endtask

  task automatic test_start_ignored;
    run_march(1'b1, 1'b1);
    checks++; if (r_done_cnt !== 1) begin errors++; $display("FAIL ignored_done_count: got %0d expected 1", r_done_cnt); end
    checks++; if (r_done_k !== 2562) begin errors++; $display("FAIL ignored_done_cycle: S+%0d expected S+2562", r_done_k); end
    checks++; if (r_busy_err !== 0 || r_trace_err !== 0) begin
      errors++; $display("FAIL ignored_no_restart: busy_err=%0d trace_err=%0d expected 0/0", r_busy_err, r_trace_err);
    end
  endtask

  task automatic test_reset_midrun;
    int en_seen;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (499) @(negedge clk);
    checks++; if (en_o !== 1'b1) begin errors++; $display("FAIL midrun_active: en=%b expected 1", en_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, fail_o, en_o, we_o} !== 5'b0 || addr_o !== '0 || wdata_o !== '0 || be_o !== '0) begin
      errors++; $display("FAIL async_reset: ctrl=%b addr=%h wdata=%h be=%h expected all 0",
                         {busy_o, done_o, fail_o, en_o, we_o}, addr_o, wdata_o, be_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    en_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (en_o !== 1'b0 || busy_o !== 1'b0) en_seen++;
    end
    checks++; if (en_seen !== 0) begin errors++; $display("FAIL post_reset_idle: %0d active cycles expected 0", en_seen); end
    run_march(1'b0, 1'b0);
    checks++;
    if (r_fail_end !== 1'b0 || r_done_k !== 2562 || r_trace_err !== 0) begin
      errors++; $display("FAIL post_reset_run: fail=%b done=S+%0d trace_err=%0d expected 0/S+2562/0", r_fail_end, r_done_k, r_trace_err);
    end
  endtask

  task automatic test_single_word;
    int wr, rd, dk, bad, bsy;
    logic fend;
    wr = 0; rd = 0; dk = -1; bad = 0; bsy = 0; fend = 1'bx;
    start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      if (en1 === 1'b1) begin
        if (addr1 !== 2'd0) bad++;
        if (we1) wr++; else rd++;
      end
      if (busy1 === 1'b1) bsy++;
      if (done1 === 1'b1) begin dk = k; fend = fail1; end
      @(negedge clk);
    end
    checks++; if (wr !== 5 || rd !== 5) begin errors++; $display("FAIL one_word_ops: wr=%0d rd=%0d expected 5/5", wr, rd); end
    checks++; if (dk !== 12) begin errors++; $display("FAIL one_word_done: S+%0d expected S+12", dk); end
    checks++; if (bsy !== 11 || bad !== 0) begin errors++; $display("FAIL one_word_busy_addr: busy=%0d bad_addr=%0d expected 11/0", bsy, bad); end
    checks++; if (fend !== 1'b0) begin errors++; $display("FAIL one_word_fail: got %b expected 0", fend); end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mem1[i] = '0;
    rdata_i = '0;
    rdata1  = '0;
    test_reset;
    test_fault_free;
    test_stuck_fault;
    test_fault_cleared;
    test_start_ignored;
    test_reset_midrun;
    test_single_word;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
